fetch_stage: RTL

- Instruction-fetch front end feeding the decode/execute core (instruction decoder → register file → ALU).
- Owns the program counter and issues word reads to instruction memory over a valid/ready request channel with variable-latency, in-order responses.
- Buffers returned instructions, tagged with their PC, in a small FIFO and presents them to decode over a valid/ready output.
- Supports redirect (branch/jump) and halt (EBREAK seen by decode).

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch front end. Owns the program counter, issues word reads to
// instruction memory over a valid/ready request channel, and tags each
// in-order response with its PC. The tagged instructions are buffered in a
// small FIFO and handed to decode over a valid/ready output. A redirect
// flushes everything and restarts fetch at a new PC. A halt stops new
// fetches until the next redirect.
//
// Parameters
//   RESET_PC    first PC fetched after reset
//   FIFO_DEPTH  output buffer entries; also the credit limit on in-flight
//               plus buffered instructions (2, 4 or 8)
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request channel (word address)
//   imem_resp_valid/data             in-order responses, >= 1 cycle latency
//   out_valid/ready, out_instr/pc    instruction stream to decode
//   redirect_valid, redirect_pc      flush and restart at redirect_pc
//   halt                             stop issuing fetches (sticky)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] fifo_head;
  logic [PW-1:0] fifo_tail;
  logic [PW-1:0] tag_head;
  logic [PW-1:0] tag_tail;

  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   tag_pc     [FIFO_DEPTH];

  logic          pop;
  logic          req_fire;
  logic          resp_drop;
  logic          resp_push;
  logic [CW:0]   credit_used;
  logic          credit_ok;

  // Handshake decode. The credit counts every instruction that will need a
  // FIFO slot (in flight or already buffered), minus the one leaving this
  // cycle, so the FIFO and tag queue can never overflow. Responses that
  // arrive in a redirect cycle belong to the old stream and are never pushed.
  always_comb begin
    out_valid      = (fifo_count != '0);
    pop            = out_valid && out_ready;
    credit_used    = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
    credit_ok      = (credit_used < {1'b0, DEPTH_C});
    imem_req_valid = !reset && (state == RUN) && !redirect_valid && credit_ok;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_drop      = imem_resp_valid && (drop_cnt != '0);
    resp_push      = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    out_instr      = out_valid ? fifo_instr[fifo_head] : '0;
    out_pc         = out_valid ? fifo_pc[fifo_head]    : '0;
  end

  // Control state: PC, run/halt, in-flight and drop counters, pointers.
  // A redirect wins over everything except reset: every response still in
  // flight (other than one landing this very cycle, which is ignored here)
  // is marked for dropping, and the FIFO and tag queue are emptied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      fifo_head   <= '0;
      fifo_tail   <= '0;
      tag_head    <= '0;
      tag_tail    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        drop_cnt   <= outstanding - CW'(imem_resp_valid);
        fifo_count <= '0;
        fifo_head  <= '0;
        fifo_tail  <= '0;
        tag_head   <= '0;
        tag_tail   <= '0;
        pc         <= redirect_pc & 32'hFFFF_FFFC;
        state      <= RUN;
      end else begin
        if (resp_drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (req_fire) begin
          pc       <= pc + 32'd4;
          tag_tail <= tag_tail + PW'(1);
        end
        if (resp_push) begin
          fifo_tail <= fifo_tail + PW'(1);
          tag_head  <= tag_head + PW'(1);
        end
        if (pop) begin
          fifo_head <= fifo_head + PW'(1);
        end
        fifo_count <= fifo_count + CW'(resp_push) - CW'(pop);
        if (state == RUN && halt) begin
          state <= HALTED;
        end
      end
    end
  end

  // Storage for the tag queue and output FIFO. Contents need no reset since
  // the pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (!reset && req_fire) begin
      tag_pc[tag_tail] <= pc;
    end
    if (!reset && resp_push) begin
      fifo_instr[fifo_tail] <= imem_resp_data;
      fifo_pc[fifo_tail]    <= tag_pc[tag_head];
    end
  end

  // A response with nothing in flight means the memory broke the protocol.
  resp_has_request : assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (outstanding != '0));

endmodule
